booth_mul_seq: RTL

Sequential radix-4 Booth multiplier that sits directly upstream of the Z register pair in the datapath. It produces the 64-bit signed product for the `mul` ALU operation, with the high half driven to Zhigh and the low half to Zlow. Operands are the Y register output (multiplicand) and the bus value (multiplier). The control unit launches a multiply with a start pulse and holds Z loading until `done`, after which it moves Zlow to LO and Zhigh to HI.

---
 rtl/booth_mul_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_seq
// Description : Sequential radix-4 Booth signed multiplier, one Booth step per
//               clock; feeds the Zhigh/Zlow register pair.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             w_clock,
    input  logic             w_clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int                CNT_W       = $clog2(WIDTH / 2 + 1);
    localparam logic [CNT_W-1:0]  c_last_step = CNT_W'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH+1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_qm1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_prod_hi;
    logic [WIDTH-1:0] r_prod_lo;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH+1:0] w_m_ext;
    logic [WIDTH+1:0] w_m2_ext;
    logic [WIDTH+1:0] w_addend;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH+1:0] w_a_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_qm1_nxt;

    always_ff @(posedge w_clock or negedge w_clear) begin
        if (!w_clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == c_last_step) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Two guard bits on A keep +/-2M exact even for the most negative operand.
    always_comb begin
        w_m_ext  = {{2{r_m[WIDTH-1]}}, r_m};
        w_m2_ext = {r_m[WIDTH-1], r_m, 1'b0};
        w_addend = '0;
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = w_m_ext;
            3'b011:         w_addend = w_m2_ext;
            3'b100:         w_addend = -w_m2_ext;
            3'b101, 3'b110: w_addend = -w_m_ext;
            default:        w_addend = '0;
        endcase
        w_sum     = r_a + w_addend;
        w_a_nxt   = {{2{w_sum[WIDTH+1]}}, w_sum[WIDTH+1:2]};
        w_q_nxt   = {w_sum[1:0], r_q[WIDTH-1:2]};
        w_qm1_nxt = r_q[1];
    end

    always_ff @(posedge w_clock or negedge w_clear) begin
        if (!w_clear) begin
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_m   <= multiplicand;
                r_a   <= '0;
                r_q   <= multiplier;
                r_qm1 <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == ST_CALC) begin
                r_a   <= w_a_nxt;
                r_q   <= w_q_nxt;
                r_qm1 <= w_qm1_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_prod_hi <= w_a_nxt[WIDTH-1:0];
                    r_prod_lo <= w_q_nxt;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign product_hi = r_prod_hi;
    assign product_lo = r_prod_lo;

endmodule
`default_nettype wire
